fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch queue between the fetch and decode stages.
// Holds the default geometry and the per-cycle operation encoding.
package fetch_queue_pkg;

   localparam int FQ_DEFAULT_DEPTH = 4;
   localparam int FQ_DEFAULT_WIDTH = 32;

   // Encoding matches the concatenation {push, pop}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fq_op_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one asynchronous read port.
// The array is never reset; valid state is tracked entirely by the queue pointers and count.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instruction} pairs between fetch and decode.
// Flush discards everything queued and incoming; there is no bypass and no full pass-through.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEFAULT_DEPTH,
   parameter int WIDTH = FQ_DEFAULT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_pc,
   input  logic [WIDTH-1:0]       in_instruction,
   output logic                   in_ready,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_pc,
   output logic [WIDTH-1:0]       out_instruction,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]      count_reg, count_next;
   logic               push, pop;
   fq_op_e             op;
   logic [2*WIDTH-1:0] head_data;

   // Handshakes depend only on registered occupancy, never on the opposite side.
   assign in_ready  = (count_reg != CW'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign op        = fq_op_e'({push, pop});
   assign count     = count_reg;

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
      end else begin
         case (op)
            OP_PUSH: begin
               wr_ptr_next = wr_ptr_reg + PW'(1);
               count_next  = count_reg + CW'(1);
            end
            OP_POP: begin
               rd_ptr_next = rd_ptr_reg + PW'(1);
               count_next  = count_reg - CW'(1);
            end
            OP_BOTH: begin
               wr_ptr_next = wr_ptr_reg + PW'(1);
               rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .DATA_W(2 * WIDTH),
      .ADDR_W(PW)
   ) u_mem (
      .clk    (clk),
      .wr_en  (push),
      .wr_addr(wr_ptr_reg),
      .wr_data({in_pc, in_instruction}),
      .rd_addr(rd_ptr_reg),
      .rd_data(head_data)
   );

   // Stale storage must not leak out when the queue is empty.
   assign out_pc          = out_valid ? head_data[2*WIDTH-1:WIDTH] : '0;
   assign out_instruction = out_valid ? head_data[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, WIDTH=32).
// Inputs change 1ns after the rising edge; outputs are checked in the same window.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instruction;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;
   logic        out_ready;
   logic [2:0]  count;

   int pass_cnt  = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_pc          (in_pc),
      .in_instruction (in_instruction),
      .in_ready       (in_ready),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instruction(out_instruction),
      .out_ready      (out_ready),
      .count          (count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   // Advance one clock and log the transaction seen at that edge.
   task automatic step();
      @(posedge clk);
      $display("t=%0t rst=%b flush=%b push=%b(pc=0x%0h) pop=%b(pc=0x%0h)", $time, rst, flush,
               in_valid && in_ready && !flush, in_pc, out_valid && out_ready && !flush, out_pc);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic r);
      in_valid       = v;
      in_pc          = pc;
      in_instruction = pc ^ 32'hA5A5_0000;
      out_ready      = r;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pc;
      int pushed;
      int model_cnt;
      logic mpush, mpop;

      rst = 1'b1; flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      step(); step();
      rst = 1'b0;
      step();
      check("rst_count", {29'b0, count}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instruction, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Two pushes held at the head while decode is frozen
      in_valid = 1'b1; in_pc = 32'd4; in_instruction = 32'hE3A0_1005; out_ready = 1'b0;
      step();
      check("no_bypass", {31'b0, out_valid}, 32'd1);
      in_pc = 32'd8; in_instruction = 32'hE281_1001;
      step();
      in_valid = 1'b0;
      check("two_count", {29'b0, count}, 32'd2);
      step(); step();
      check("stall_pc", out_pc, 32'd4);
      check("stall_instr", out_instruction, 32'hE3A0_1005);
      out_ready = 1'b1;
      step();
      check("pop2_pc", out_pc, 32'd8);
      check("pop2_instr", out_instruction, 32'hE281_1001);
      step();
      check("drain_count", {29'b0, count}, 32'd0);
      check("drain_out_pc", out_pc, 32'd0);

      // Fill, reject a fifth push, then pop one
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h10 + 32'(4 * i), 1'b0);
         step();
      end
      check("full_count", {29'b0, count}, 32'd4);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      drive(1'b1, 32'h20, 1'b0);
      step();
      check("fifth_ignored", {29'b0, count}, 32'd4);
      drive(1'b0, 32'h0, 1'b1);
      step();
      check("pop_ready", {31'b0, in_ready}, 32'd1);
      check("pop_count", {29'b0, count}, 32'd3);
      check("pop_next_pc", out_pc, 32'h14);
      step(); step(); step();
      check("empty_after", {29'b0, count}, 32'd0);

      // Full queue: simultaneous pop and rejected push
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
         step();
      end
      drive(1'b1, 32'h200, 1'b1);
      check("full_pop_ready", {31'b0, in_ready}, 32'd0);
      step();
      check("full_pop_count", {29'b0, count}, 32'd3);
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 1; i < 4; i++) begin
         check("full_pop_order", out_pc, 32'h100 + 32'(4 * i));
         step();
      end
      check("full_pop_empty", {29'b0, count}, 32'd0);

      // Ten pushes with interleaved pops across pointer wrap
      exp_pc = 4; pushed = 0; model_cnt = 0;
      for (int cyc = 0; cyc < 80 && exp_pc <= 40; cyc++) begin
         drive(pushed < 10, 32'(4 * (pushed + 1)), (cyc >= 5) && (cyc % 2 == 0));
         mpush = in_valid && (model_cnt != 4);
         mpop  = out_ready && (model_cnt != 0);
         if (mpop) check("wrap_order", out_pc, 32'(exp_pc));
         step();
         if (mpush) pushed++;
         if (mpop) exp_pc += 4;
         model_cnt = model_cnt + int'(mpush) - int'(mpop);
         check("wrap_count", {29'b0, count}, 32'(model_cnt));
      end
      check("wrap_all_popped", 32'(exp_pc), 32'd44);
      drive(1'b0, 32'h0, 1'b0);

      // Flush beats push and pop
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
         step();
      end
      drive(1'b1, 32'h400, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      check("flush_count", {29'b0, count}, 32'd0);
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
      check("flush_out_pc", out_pc, 32'd0);
      drive(1'b1, 32'h500, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      check("post_flush_pc", out_pc, 32'h500);
      check("post_flush_count", {29'b0, count}, 32'd1);

      // Reset mid-operation overrides a push
      drive(1'b1, 32'h600, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      check("midrst_count", {29'b0, count}, 32'd0);
      check("midrst_ready", {31'b0, in_ready}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
